mlaccel_memory_reader: RTL and testbench



---
 rtl/mlaccel_memory_reader.sv | 196 +++++++++++++++++++
 tb/tb_mlaccel_memory_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_memory_reader.sv
// Generic FIFO for the memory reader output buffer.
// Latency: pushed entry visible at head the cycle after push; head is combinational from storage.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module mlaccel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
endmodule

// Burst reader / single-word writer for the unified 16-bit-word memory.
// Latency: first beat READ_LATENCY+1 cycles after the first read issue, then one beat per cycle.
// Backpressure: reads issue only while buffered plus in-flight beats fit the FIFO, so out_ready stalls issue.
module mlaccel_memory_reader #(
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [1:0]  wr_wen,
    input  logic [15:0] wr_wdata,
    output logic [15:0] mem_addr,
    output logic [1:0]  mem_wen,
    output logic [15:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic [3:0] keep;
        logic       last;
    } tag_t;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic [1:0]              state;
    logic [15:0]             ptr, rem, rem_take;
    logic [CW-1:0]           inflight, fifo_count;
    logic [READ_LATENCY-1:0] pipe_vld;
    tag_t                    tag_pipe [READ_LATENCY];
    tag_t                    issue_tag;
    beat_t                   head, push_beat;
    logic                    fifo_empty, wr_fire, cmd_fire, issue, capture, pop;

    assign fifo_empty = (fifo_count == '0);
    assign wr_ready   = (state == IDLE) && fifo_empty;
    assign cmd_ready  = (state == IDLE) && fifo_empty && !wr_valid;
    assign wr_fire    = wr_valid && wr_ready;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign issue      = (state == READ) && (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
    assign capture    = pipe_vld[READ_LATENCY-1];
    assign pop        = out_valid && out_ready;
    assign rem_take   = (rem >= 16'd4) ? 16'd4 : rem;

    always_comb begin
        issue_tag      = '0;
        issue_tag.last = (rem <= 16'd4);
        if (rem >= 16'd4) begin
            issue_tag.keep = 4'b1111;
        end else begin
            case (rem[1:0])
                2'd3:    issue_tag.keep = 4'b0111;
                2'd2:    issue_tag.keep = 4'b0011;
                2'd1:    issue_tag.keep = 4'b0001;
                default: issue_tag.keep = 4'b0000;
            endcase
        end
    end

    // Writes are only taken in IDLE, so the memory port is never shared within a cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wen   = '0;
        mem_wdata = '0;
        if (wr_fire) begin
            mem_addr  = wr_addr;
            mem_wen   = wr_wen;
            mem_wdata = wr_wdata;
        end else if (state == READ) begin
            mem_addr = ptr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            inflight <= '0;
            pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            pipe_vld[0] <= issue;
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            inflight <= inflight + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, capture};
            case (state)
                IDLE: begin
                    if (cmd_fire && cmd_len != 16'd0) begin
                        ptr   <= cmd_addr;
                        rem   <= cmd_len;
                        state <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        ptr <= ptr + 16'd4;
                        rem <= rem - rem_take;
                        if (issue_tag.last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push_beat = {mem_rdata, tag_pipe[READ_LATENCY-1]};

    mlaccel_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (capture),
        .push_dat (push_beat),
        .pop      (pop),
        .head_dat (head),
        .count    (fifo_count)
    );

    assert property (@(posedge clock) disable iff (reset)
        !(capture && int'(fifo_count) == FIFO_DEPTH && !pop));

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head.data : '0;
    assign out_keep  = out_valid ? head.keep : '0;
    assign out_last  = out_valid ? head.last : 1'b0;
    assign busy      = (state != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mlaccel_memory_reader.sv
// Bench for mlaccel_memory_reader: latency-2 memory model, shadow-memory beat predictor, directed and random bursts.
module tb_mlaccel_memory_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid, cmd_ready, wr_valid, wr_ready;
    logic [15:0] cmd_addr, cmd_len, wr_addr, wr_wdata, mem_addr, mem_wdata;
    logic [1:0]  wr_wen, mem_wen;
    logic [63:0] mem_rdata, rd_stage, out_data;
    logic        out_valid, out_ready, out_last, busy;
    logic [3:0]  out_keep;

    mlaccel_memory_reader #(.READ_LATENCY(2), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_wen(wr_wen), .wr_wdata(wr_wdata),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    int valid_cnt = 0;
    int cmd_cyc = 0;
    bit in_reset = 1'b1;

    logic [15:0] mem     [65536];
    logic [15:0] ref_mem [65536];
    logic [63:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    logic        exp_last[$];
    logic [63:0] seen_data[$];
    logic [3:0]  seen_keep[$];
    logic        seen_last[$];
    int          hs_cyc[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_window(input logic [15:0] a);
        logic [63:0] w;
        logic [15:0] ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 16'(i);
            w[16*i +: 16] = mem[ai];
        end
        return w;
    endfunction

    function automatic logic [63:0] ref_window(input logic [15:0] a);
        logic [63:0] w;
        logic [15:0] ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 16'(i);
            w[16*i +: 16] = ref_mem[ai];
        end
        return w;
    endfunction

    // Memory: byte-enabled write, two-cycle registered read of the four-word window.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem_rdata = '0;
        rd_stage  = '0;
        forever begin
            @(posedge clock);
            mem_rdata <= rd_stage;
            rd_stage  <= mem_window(mem_addr);
            if (mem_wen[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
            if (mem_wen[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
        end
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Output checker: beat order/content against predicted queue, and hold-while-stalled.
    initial begin
        logic        pv, pr, pl, el;
        logic [63:0] pd, ed, m;
        logic [3:0]  pk, ek;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pk = '0;
        forever begin
            @(negedge clock);
            if (in_reset) begin
                pv = 1'b0;
            end else begin
                if (out_valid) valid_cnt++;
                if (pv && !pr)
                    check("hold_stable", {out_valid, out_keep, out_last, out_data}, {1'b1, pk, pl, pd});
                if (out_valid && out_ready) begin
                    if (exp_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %h keep %b, required no beat", out_data, out_keep);
                    end else begin
                        ed = exp_data.pop_front();
                        ek = exp_keep.pop_front();
                        el = exp_last.pop_front();
                        m = '0;
                        for (int i = 0; i < 4; i++) if (ek[i]) m[16*i +: 16] = 16'hFFFF;
                        check("beat_data", out_data & m, ed & m);
                        check("beat_keep", out_keep, ek);
                        check("beat_last", out_last, el);
                        seen_data.push_back(out_data);
                        seen_keep.push_back(out_keep);
                        seen_last.push_back(out_last);
                        hs_cyc.push_back(cyc);
                    end
                end
                pv = out_valid; pr = out_ready; pd = out_data; pk = out_keep; pl = out_last;
            end
        end
    end

    task automatic clear_seen();
        seen_data.delete();
        seen_keep.delete();
        seen_last.delete();
        hs_cyc.delete();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [1:0] wen, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        wr_valid = 1'b1; wr_addr = a; wr_wen = wen; wr_wdata = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (wr_ready) begin
                ok = 1'b1;
                check("wr_mem_addr", mem_addr, a);
                check("wr_mem_wen", mem_wen, wen);
                check("wr_mem_wdata", mem_wdata, d);
                if (wen[0]) ref_mem[a][7:0]  = d[7:0];
                if (wen[1]) ref_mem[a][15:8] = d[15:8];
            end
            @(posedge clock);
            #1;
        end
        wr_valid = 1'b0;
        check("wr_accepted", ok, 1'b1);
    endtask

    task automatic do_cmd(input logic [15:0] a, input logic [15:0] len, output int waited);
        bit ok;
        int nb, left;
        ok = 1'b0;
        waited = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = len;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1'b1;
                cmd_cyc = cyc;
                nb = (int'(len) + 3) / 4;
                for (int b = 0; b < nb; b++) begin
                    left = int'(len) - 4 * b;
                    exp_data.push_back(ref_window(a + 16'(4 * b)));
                    exp_keep.push_back(left >= 4 ? 4'hF : 4'((1 << left) - 1));
                    exp_last.push_back(b == nb - 1);
                end
            end else begin
                waited++;
            end
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (exp_data.size() == 0 && !busy) done = 1'b1;
        end
        @(posedge clock);
        #1;
        check("idle_reached", done, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    initial begin
        int w;
        logic [15:0] base, a, d, len;
        logic [1:0]  wen;
        logic [63:0] sd;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_wen = '0; wr_wdata = '0;
        mode = 0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_keep", out_keep, 4'h0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_mem_wen", mem_wen, 2'b00);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_busy", busy, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_reset = 1'b0;
        @(negedge clock);
        check("idle_cmd_ready", cmd_ready, 1'b1);
        check("idle_wr_ready", wr_ready, 1'b1);
        @(posedge clock);
        #1;

        for (int i = 0; i < 16; i++) do_write(16'(i), 2'b11, 16'(i));

        // Aligned 8-word burst, full throughput.
        clear_seen(); mode = 0;
        do_cmd(16'h0000, 16'd8, w);
        wait_idle();
        check("t1_beats", seen_data.size(), 2);
        check("t1_data0", seen_data[0], 64'h0003000200010000);
        check("t1_keep0", seen_keep[0], 4'hF);
        check("t1_last0", seen_last[0], 1'b0);
        check("t1_data1", seen_data[1], 64'h0007000600050004);
        check("t1_last1", seen_last[1], 1'b1);
        check("t1_lead", hs_cyc[0] - cmd_cyc, 4);
        check("t1_b2b", hs_cyc[1] - hs_cyc[0], 1);

        // Unaligned start, partial tail, random backpressure.
        clear_seen(); mode = 2;
        do_cmd(16'h0005, 16'd6, w);
        wait_idle();
        check("t2_beats", seen_data.size(), 2);
        check("t2_data0", seen_data[0], 64'h0008000700060005);
        check("t2_keep0", seen_keep[0], 4'hF);
        sd = seen_data[1];
        check("t2_data1", sd[31:0], 32'h000A0009);
        check("t2_keep1", seen_keep[1], 4'b0011);
        check("t2_last1", seen_last[1], 1'b1);

        // 16 words with out_ready cycling 1-0-0-1.
        clear_seen(); mode = 1;
        do_cmd(16'h0000, 16'd16, w);
        wait_idle();
        check("t3_beats", seen_data.size(), 4);
        check("t3_data0", seen_data[0], 64'h0003000200010000);
        check("t3_data3", seen_data[3], 64'h000F000E000D000C);
        check("t3_last3", seen_last[3], 1'b1);

        // Sustained rate over eight beats.
        clear_seen(); mode = 0;
        do_cmd(16'h0000, 16'd32, w);
        wait_idle();
        check("tp_beats", seen_data.size(), 8);
        check("tp_span", hs_cyc[7] - hs_cyc[0], 7);

        // Window straddling the top of the address space.
        do_write(16'hFFFE, 2'b11, 16'hAAAA);
        do_write(16'hFFFF, 2'b11, 16'hBBBB);
        do_write(16'h0000, 2'b11, 16'hCCCC);
        clear_seen(); mode = 0;
        do_cmd(16'hFFFE, 16'd3, w);
        wait_idle();
        check("wrap_beats", seen_data.size(), 1);
        sd = seen_data[0];
        check("wrap_data", sd[47:0], 48'hCCCCBBBBAAAA);
        check("wrap_keep", seen_keep[0], 4'b0111);
        check("wrap_last", seen_last[0], 1'b1);

        // Zero-length command.
        valid_cnt = 0;
        do_cmd(16'h0010, 16'd0, w);
        @(negedge clock);
        check("len0_busy", busy, 1'b0);
        check("len0_cmd_ready", cmd_ready, 1'b1);
        repeat (5) @(negedge clock);
        check("len0_no_beat", valid_cnt, 0);
        @(posedge clock);
        #1;

        // Write and command together: write wins, command next cycle sees new data.
        wr_valid = 1'b1; wr_addr = 16'h0040; wr_wen = 2'b11; wr_wdata = 16'h1234;
        cmd_valid = 1'b1; cmd_addr = 16'h0040; cmd_len = 16'd1;
        @(negedge clock);
        check("both_wr_ready", wr_ready, 1'b1);
        check("both_cmd_blocked", cmd_ready, 1'b0);
        check("both_mem_wen", mem_wen, 2'b11);
        if (wr_ready) ref_mem[16'h0040] = 16'h1234;
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        clear_seen();
        do_cmd(16'h0040, 16'd1, w);
        check("both_cmd_next", w, 0);
        wait_idle();
        sd = seen_data[0];
        check("both_data", sd[15:0], 16'h1234);
        check("both_keep", seen_keep[0], 4'b0001);

        // Reset mid-burst with beats buffered.
        mode = 3;
        do_cmd(16'h0000, 16'd16, w);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("pre_rst_valid", out_valid, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_reset = 1'b1;
        exp_data.delete(); exp_keep.delete(); exp_last.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_mem_wen", mem_wen, 2'b00);
        repeat (2) @(posedge clock);
        #1;
        mode = 0;
        valid_cnt = 0;
        reset = 1'b0;
        in_reset = 1'b0;
        repeat (12) @(negedge clock);
        check("postrst_busy", busy, 1'b0);
        check("postrst_no_beat", valid_cnt, 0);
        @(posedge clock);
        #1;

        // Random writes and bursts around a low region and the wrap point.
        for (int n = 0; n < 40; n++) begin
            base = ($urandom_range(0, 1) == 1) ? 16'h0100 : 16'hFFE0;
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < 3; k++) begin
                    a   = base + 16'($urandom_range(0, 63));
                    wen = 2'($urandom_range(1, 3));
                    d   = 16'($urandom);
                    do_write(a, wen, d);
                end
            end else begin
                mode = $urandom_range(0, 2);
                a    = base + 16'($urandom_range(0, 47));
                len  = 16'($urandom_range(0, 24));
                do_cmd(a, len, w);
                wait_idle();
            end
        end

        check("leftover_beats", exp_data.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
